arbitro_roteamento: RTL

ARBITRO_ROTEAMENTO -- requirements
Module: arbitro_roteamento

---
 rtl/arbitro_pkg.sv | 12 +
 rtl/fifo_canal.sv | 66 ++++++
 rtl/arbitro_roteamento.sv | 92 +++++++++
 3 files changed

// File: rtl/arbitro_pkg.sv
// Purpose: shared defaults and round-robin state type for the routing arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arbitro_pkg;

    localparam int LARGURA_PADRAO      = 4;
    localparam int PROFUNDIDADE_PADRAO = 2;

    // PRIO_A: A wins the next tie; PRIO_B: B wins the next tie.
    typedef enum logic {PRIO_A, PRIO_B} prio_t;

endpackage

// File: rtl/fifo_canal.sv
// Purpose: per-channel synchronous FIFO (push/pop/full/empty), head word visible combinationally.
// Latency: a word pushed at edge k is at the head after edge k.
// Backpressure: push ignored while full, pop ignored while empty; cheio/vazio come from registers only.
// Ports: clk, reset (sync, active-high), push/din write side, pop/dout read side, cheio/vazio status.
module fifo_canal #(
    parameter int LARGURA      = 4,
    parameter int PROFUNDIDADE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [LARGURA-1:0] din,
    input  logic               pop,
    output logic [LARGURA-1:0] dout,
    output logic               cheio,
    output logic               vazio
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int CW = PW + 1;

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      cont;

    logic push_ok;
    logic pop_ok;

    assign push_ok = push && !cheio;
    assign pop_ok  = pop && !vazio;

    assign cheio = (cont == CW'(PROFUNDIDADE));
    assign vazio = (cont == '0);
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; emptiness is tracked by cont alone.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are PW bits wide, so with a power-of-two depth they wrap for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cont   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push_ok && !pop_ok) begin
                cont <= cont + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cont <= cont - 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_roteamento.sv
// Purpose: merges channels A and B into one registered output with round-robin arbitration on ties.
// Latency: word pushed at edge k into an empty block is on saida with saida_valid after edge k+1.
// Backpressure: x_pronto = FIFO not full (registered); saida/sel hold while saida_valid && !saida_pronto.
// Ports: clk, reset (sync, active-high); a_/b_ dado/valid/pronto inputs; saida/saida_valid/saida_pronto, sel.
module arbitro_roteamento
    import arbitro_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LARGURA-1:0] a_dado,
    input  logic               a_valid,
    output logic               a_pronto,
    input  logic [LARGURA-1:0] b_dado,
    input  logic               b_valid,
    output logic               b_pronto,
    output logic               sel,
    output logic [LARGURA-1:0] saida,
    output logic               saida_valid,
    input  logic               saida_pronto
);

    logic               a_cheio, a_vazio, b_cheio, b_vazio;
    logic [LARGURA-1:0] a_cab, b_cab;
    logic               a_push, b_push, a_pop, b_pop;
    logic               carrega;
    logic               concede_b;
    prio_t              prio;

    assign a_pronto = !a_cheio;
    assign b_pronto = !b_cheio;
    assign a_push   = a_valid && a_pronto;
    assign b_push   = b_valid && b_pronto;

    // Register refills when empty or being drained this cycle, and something is waiting.
    assign carrega = (!saida_valid || saida_pronto) && (!a_vazio || !b_vazio);

    // B wins when it is the only one waiting, or on a tie when the pointer says so.
    assign concede_b = !b_vazio && (a_vazio || (prio == PRIO_B));

    assign a_pop = carrega && !concede_b;
    assign b_pop = carrega && concede_b;

    fifo_canal #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (a_push),
        .din   (a_dado),
        .pop   (a_pop),
        .dout  (a_cab),
        .cheio (a_cheio),
        .vazio (a_vazio)
    );

    fifo_canal #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (b_push),
        .din   (b_dado),
        .pop   (b_pop),
        .dout  (b_cab),
        .cheio (b_cheio),
        .vazio (b_vazio)
    );

    // Output register and round-robin pointer; the pointer only moves on a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            saida       <= '0;
            saida_valid <= 1'b0;
            sel         <= 1'b0;
            prio        <= PRIO_A;
        end else if (carrega) begin
            saida       <= concede_b ? b_cab : a_cab;
            sel         <= concede_b;
            saida_valid <= 1'b1;
            prio        <= concede_b ? PRIO_A : PRIO_B;
        end else if (saida_pronto) begin
            // Drained with nothing to reload: saida and sel keep their last values.
            saida_valid <= 1'b0;
        end
    end

endmodule
